dmem_responder: RTL and testbench

- Responder end of the core's data-memory interface.
- Accepts one load/store request at a time over a valid/ready handshake, applies a configurable wait-state latency, and then commits the access to an internal word-addressed RAM.
- Returns a held response (read data plus error flag) over a second valid/ready handshake.
- Sits between the core's memory port and the data RAM, replacing the zero-latency direct RAM hookup.

---
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder: data-memory responder with wait states and word RAM behind
// a request/response valid-ready pair. Optional macro: DMEM_ALIGN_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH   = 10240,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [29:0] idx;
  logic        commit;
  logic        out_of_range;
  logic        misalign;
  logic        err_now;
  logic [31:0] rd_word;

  assign idx          = addr_q[31:2];
  assign commit       = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign out_of_range = ({2'b00, idx} >= DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |addr_q[1:0];
`else
  logic unused_addr_lsb;
  assign misalign        = 1'b0;
  assign unused_addr_lsb = |addr_q[1:0];
`endif

  assign err_now = out_of_range | misalign;
  // Faulted accesses never touch the array, so the read mux only matters in range.
  assign rd_word = out_of_range ? 32'd0 : mem_q[idx[AW-1:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 4'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = (we_q || err_now) ? 32'd0 : rd_word;
          err_d   = err_now;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; a reset edge leaves state IDLE so no commit occurs.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err_now && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH = 10240;
  localparam int LAT   = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE, complete its response handshake, return the response.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic err);
    int n;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, LAT + 1);
    rd  = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("rdata_held", rsp_rdata, rd);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] hold_rd;
  logic        hold_er;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Basic store then load
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
    chk("st10_err", {31'd0, er}, 32'd0);
    chk("st10_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_err", {31'd0, er}, 32'd0);

    // Partial byte-enable store
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er);
    chk("be5_merge", rd, 32'h11BB33DD);

    // be=0 store is a no-op without error
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er);
    chk("be0_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er);
    chk("be0_nowrite", rd, 32'h11BB33DD);

    // Range check
    do_req(1'b1, 32'h0, 32'h12345678, 4'hF, rd, er);
    do_req(1'b0, 32'hA000, 32'h0, 4'h0, rd, er);
    chk("oor_ld_err", {31'd0, er}, 32'd1);
    chk("oor_ld_rdata", rd, 32'd0);
    do_req(1'b1, 32'hA000, 32'hFFFF0000, 4'hF, rd, er);
    chk("oor_st_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er);
    chk("idx0_unchanged", rd, 32'h12345678);
    do_req(1'b0, 32'h9FFC, 32'h0, 4'h0, rd, er);
    chk("last_idx_err", {31'd0, er}, 32'd0);

    // Hold response for 5 cycles while a second request is presented
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("hold_valid_rise", {31'd0, rsp_valid}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("hold_err", {31'd0, rsp_err}, 32'd0);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("hs_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("next_accept", {31'd0, busy}, 32'd1);
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("next_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("next_store_data", rd, 32'hCAFEF00D);

    // Reset during WAIT drops the store
    do_req(1'b1, 32'h30, 32'h0, 4'hF, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, er);
    chk("midrst_nostore", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("ram_persists", rd, 32'hCAFEF00D);

    // Alignment handling
    do_req(1'b1, 32'h40, 32'h01010101, 4'hF, rd, er);
    do_req(1'b1, 32'h42, 32'h0BADCAFE, 4'hF, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("align_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er);
    chk("align_nowrite", rd, 32'h01010101);
`else
    chk("align_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er);
    chk("align_write", rd, 32'h0BADCAFE);
    chk("align_ld_err", {31'd0, er}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
